// File: rtl/weight_mem_arbiter.sv
// -----------------------------------------------------------------------------
// weight_mem_arbiter
//
// Shares one single-port weight RAM between three requesters:
//   requester 0 = weight loader, 1 = back-prop, 2 = forward-prop.
// A round-robin choice is made in IDLE (one dead cycle per grant). The chosen
// owner then gets one access per cycle for as long as it keeps req high, up to
// MAX_BURST accesses. After that the grant is released and arbitration runs
// again. Read data comes back from the RAM one cycle after the access. It is
// broadcast on rdata and qualified per requester by rvalid.
//
// Ports
//   clk        in   single clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   req[2:0]   in   per-requester request
//   we[2:0]    in   per-requester write enable (qualified by req)
//   addr       in   3*ADDR_W, slice i belongs to requester i
//   wdata      in   3*DATA_W, slice i belongs to requester i
//   gnt[2:0]   out  registered one-hot grant
//   rvalid     out  per-requester read-data valid
//   rdata      out  read data (mem_rdata passed straight through)
//   mem_en     out  RAM access enable
//   mem_we     out  RAM write enable
//   mem_addr   out  RAM address
//   mem_wdata  out  RAM write data
//   mem_rdata  in   RAM read data, valid one cycle after mem_en
//   busy       out  an owner currently holds the RAM
// -----------------------------------------------------------------------------
module weight_mem_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int                BEAT_W   = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] MAX_BEAT = BEAT_W'(MAX_BURST);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t              state, state_n;
    logic [1:0]          owner, owner_n;
    logic [1:0]          last_owner, last_owner_n;
    logic [BEAT_W-1:0]   beat, beat_n;
    logic [2:0]          gnt_n;
    logic [2:0]          rvalid_n;
    logic                accept;

    // Requester index 0..2 wraps back to 0 after 2.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    // Owner's request signals, muxed out of the packed per-requester buses.
    logic                own_req;
    logic                own_we;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        case (owner)
            2'd0: begin
                own_req   = req[0];
                own_we    = we[0];
                own_addr  = addr[0*ADDR_W +: ADDR_W];
                own_wdata = wdata[0*DATA_W +: DATA_W];
            end
            2'd1: begin
                own_req   = req[1];
                own_we    = we[1];
                own_addr  = addr[1*ADDR_W +: ADDR_W];
                own_wdata = wdata[1*DATA_W +: DATA_W];
            end
            2'd2: begin
                own_req   = req[2];
                own_we    = we[2];
                own_addr  = addr[2*ADDR_W +: ADDR_W];
                own_wdata = wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // Round-robin pick: first requester with req set, searching upward from
    // last_owner+1 and wrapping.
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;

    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        cand  = next_idx(last_owner);
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = next_idx(cand);
        end
    end

    // Next-state logic.
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        beat_n       = beat;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_n = pick;
                    beat_n  = '0;
                    state_n = OWN;
                end
            end
            OWN: begin
                if (own_req) begin
                    // Reset blocks the access itself. The state update is
                    // overridden by the reset branch of the register anyway.
                    accept = !rst;
                    beat_n = beat + BEAT_W'(1);
                    if (beat_n == MAX_BEAT) begin
                        last_owner_n = owner;
                        state_n      = IDLE;
                    end
                end else begin
                    last_owner_n = owner;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        gnt_n    = (state_n == OWN) ? onehot(owner_n) : 3'b000;
        rvalid_n = (accept && !own_we) ? onehot(owner) : 3'b000;
    end

    // Memory port is driven only in the cycle of an accepted access and is
    // held at zero otherwise. Non-owners therefore never reach it.
    always_comb begin
        mem_en    = accept;
        mem_we    = accept & own_we;
        mem_addr  = accept ? own_addr  : '0;
        mem_wdata = accept ? own_wdata : '0;
    end

    assign rdata = mem_rdata;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples values from before this edge.
        if (rst) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd2;
            beat       <= '0;
            gnt        <= 3'b000;
            busy       <= 1'b0;
            rvalid     <= 3'b000;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            beat       <= beat_n;
            gnt        <= gnt_n;
            busy       <= (state_n == OWN);
            rvalid     <= rvalid_n;
        end
    end

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_weight_mem_arbiter
//
// Directed stimulus for weight_mem_arbiter (MAX_BURST = 4). The bench contains
// a read-only RAM with a fixed content function and a cycle-level model of the
// arbitration rules. A compare process checks every DUT output against that
// model on each falling edge. The directed scenarios also check hand-computed
// literal values at chosen cycles.
// -----------------------------------------------------------------------------
module tb_weight_mem_arbiter;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [2:0]            req = '0;
    logic [2:0]            we  = '0;
    logic [3*ADDR_W-1:0]   addr  = '0;
    logic [3*DATA_W-1:0]   wdata = '0;
    logic [2:0]            gnt;
    logic [2:0]            rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata = '0;
    logic                  busy;

    int n_checks = 0;
    int n_errors = 0;

    weight_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM content: fixed function of address. Writes are absorbed and not read back.
    function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
        case (a)
            17'd5:   return 16'h000A;
            17'd6:   return 16'h000B;
            17'd7:   return 16'h000C;
            default: return 16'(a * 7 + 3);
        endcase
    endfunction

    always @(posedge clk)
        if (mem_en && !mem_we) mem_rdata <= rom(mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model. m_owner = -1 means no owner. m_rv = -1 means no read is returning.
    // ------------------------------------------------------------------------
    int              m_owner = -1;
    int              m_last  = 2;
    int              m_beats = 0;
    int              m_rv    = -1;
    logic [DATA_W-1:0] m_rv_data = '0;
    bit              live = 1'b0;

    initial begin
        forever begin
            logic              acc;
            logic              e_we;
            logic [ADDR_W-1:0] e_addr;
            logic [DATA_W-1:0] e_wd;
            logic [2:0]        e_gnt, e_rv;
            @(negedge clk);
            acc = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_gnt = '0; e_rv = '0;
            if (m_owner >= 0) begin
                e_gnt = 3'(1 << m_owner);
                acc   = req[m_owner] && !rst;
            end
            if (acc) begin
                e_we   = we[m_owner];
                e_addr = addr[m_owner*ADDR_W +: ADDR_W];
                e_wd   = wdata[m_owner*DATA_W +: DATA_W];
            end
            if (m_rv >= 0) e_rv = 3'(1 << m_rv);
            if (live) begin
                check("model gnt",       gnt,       e_gnt);
                check("model busy",      busy,      (m_owner >= 0));
                check("model mem_en",    mem_en,    acc);
                check("model mem_we",    mem_we,    e_we);
                check("model mem_addr",  mem_addr,  e_addr);
                check("model mem_wdata", mem_wdata, e_wd);
                check("model rvalid",    rvalid,    e_rv);
                if (m_rv >= 0) check("model rdata", rdata, m_rv_data);
            end
            // Advance the model to the state after the coming rising edge.
            if (rst) begin
                m_owner = -1; m_last = 2; m_beats = 0; m_rv = -1; live = 1'b1;
            end else if (m_owner >= 0) begin
                if (acc) begin
                    m_beats++;
                    m_rv      = e_we ? -1 : m_owner;
                    m_rv_data = rom(e_addr);
                    if (m_beats == MAX_BURST) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end
                end else begin
                    m_rv    = -1;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else begin
                m_rv = -1;
                for (int k = 1; k <= 3; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % 3]) begin
                        m_owner = (m_last + k) % 3;
                        m_beats = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input int a);
        addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic set_wdata(input int i, input int d);
        wdata[i*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; we = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq [16];
        logic [2:0] exp_seq [16];
        int writes, cyc, first_run, gap_gnt;
        bit seen_gap;

        // ---- Reset, then all three request reads -------------------------
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset gnt",    gnt,    3'b000);
        check("reset busy",   busy,   1'b0);
        check("reset rvalid", rvalid, 3'b000);
        check("reset mem_en", mem_en, 1'b0);
        tick();
        set_addr(0, 32); set_addr(1, 33); set_addr(2, 34);
        req = 3'b111;
        exp_seq = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001,
                    3'b000, 3'b010, 3'b010, 3'b010, 3'b010,
                    3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            seq[i] = gnt;
            tick();
        end
        req = '0;
        for (int i = 0; i < 16; i++) check($sformatf("rr gnt[%0d]", i), seq[i], exp_seq[i]);
        tick();
        tick();

        // ---- Requester 2 reads 5, 6, 7 -----------------------------------
        do_reset();
        req = 3'b100; we = '0; set_addr(2, 5);
        tick();
        @(negedge clk);
        check("rd2 gnt", gnt, 3'b100);
        check("rd2 mem_addr 5", mem_addr, 17'd5);
        tick(); set_addr(2, 6);
        @(negedge clk);
        check("rd2 rvalid a", rvalid, 3'b100);
        check("rd2 rdata a",  rdata,  16'h000A);
        tick(); set_addr(2, 7);
        @(negedge clk);
        check("rd2 rvalid b", rvalid, 3'b100);
        check("rd2 rdata b",  rdata,  16'h000B);
        tick(); req = '0;
        @(negedge clk);
        check("rd2 mem_en off", mem_en, 1'b0);
        check("rd2 rvalid c",   rvalid, 3'b100);
        check("rd2 rdata c",    rdata,  16'h000C);
        tick();
        @(negedge clk);
        check("rd2 rvalid end", rvalid, 3'b000);
        tick();

        // ---- Requester 1 writes 10 words with MAX_BURST = 4 --------------
        do_reset();
        req = 3'b010; we = 3'b010; set_addr(1, 16); set_wdata(1, 16'h100);
        tick();
        writes = 0; cyc = 0; first_run = 0; gap_gnt = 7; seen_gap = 1'b0;
        while (writes < 10 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) gap_gnt = int'(gnt);
            if (mem_en && mem_we) begin
                writes++;
                if (!seen_gap) first_run++;
            end else if (gnt == 3'b000) begin
                seen_gap = 1'b1;
            end
            tick();
            set_addr(1, 16 + writes);
            set_wdata(1, 16'h100 + writes);
        end
        req = '0; we = '0;
        check("wr1 writes",    writes,    10);
        check("wr1 cycles",    cyc,       12);
        check("wr1 first run", first_run, MAX_BURST);
        check("wr1 gap gnt",   gap_gnt,   0);
        tick();
        tick();

        // ---- Requester 0 bursting while requester 2 rises -----------------
        do_reset();
        req = 3'b001; we = '0; set_addr(0, 16'h10); set_addr(2, 16'h22);
        tick();
        @(negedge clk);
        check("hold gnt 1", gnt, 3'b001);
        for (int i = 0; i < 3; i++) begin
            tick(); req = 3'b101;
            @(negedge clk);
            check($sformatf("hold gnt %0d", i + 2), gnt, 3'b001);
            check($sformatf("hold addr %0d", i + 2), mem_addr, 17'h10);
        end
        tick();
        @(negedge clk);
        check("hold gap gnt", gnt, 3'b000);
        check("hold gap en",  mem_en, 1'b0);
        tick();
        @(negedge clk);
        check("hold r2 gnt",  gnt, 3'b100);
        check("hold r2 addr", mem_addr, 17'h22);
        tick(); req = '0;
        tick();
        tick();

        // ---- Reset during requester 1's read burst -----------------------
        do_reset();
        req = 3'b010; we = '0; set_addr(1, 6);
        tick();
        tick(); rst = 1'b1;
        @(negedge clk);
        check("rst no access", mem_en, 1'b0);
        tick(); rst = 1'b0; req = 3'b011; set_addr(0, 9);
        @(negedge clk);
        check("rst gnt",      gnt,      3'b000);
        check("rst rvalid",   rvalid,   3'b000);
        check("rst busy",     busy,     1'b0);
        check("rst mem_addr", mem_addr, 17'd0);
        tick();
        @(negedge clk);
        check("rst first r0", gnt, 3'b001);
        tick(); req = '0;
        tick();
        tick();

        // ---- Requester 0 drops req mid-grant -----------------------------
        do_reset();
        req = 3'b011; we = '0; set_addr(0, 1); set_addr(1, 2);
        tick();
        @(negedge clk);
        check("drop gnt0",   gnt,    3'b001);
        check("drop en0",    mem_en, 1'b1);
        tick(); req = 3'b010;
        @(negedge clk);
        check("drop no en",  mem_en, 1'b0);
        check("drop busy",   busy,   1'b1);
        tick();
        @(negedge clk);
        check("drop idle",   gnt,    3'b000);
        tick();
        @(negedge clk);
        check("drop gnt1",   gnt,    3'b010);
        check("drop addr1",  mem_addr, 17'd2);
        tick(); req = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
